// File: rtl/reg_block_reader_if.sv
// Bundles the command, register-file and output-stream signals of reg_block_reader.
// master = the reader itself; slave = the surrounding environment.
interface reg_block_reader_if;
   logic        start;
   logic [7:0]  start_addr;
   logic [7:0]  count;
   logic        abort;
   logic        busy;
   logic        done;
   logic [7:0]  reg_addr;
   logic [31:0] reg_rdata;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (
      input  start, start_addr, count, abort, reg_rdata, out_ready,
      output busy, done, reg_addr, out_data, out_valid, out_last
   );

   modport slave (
      output start, start_addr, count, abort, reg_rdata, out_ready,
      input  busy, done, reg_addr, out_data, out_valid, out_last
   );
endinterface

// File: rtl/reg_block_reader.sv
// Walks a register address range, captures each read result after RD_LAT clocks
// and streams the words through a credit-limited FIFO with a last marker.
module reg_block_reader #(
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                sysclk,
   input logic                reset,
   reg_block_reader_if.master bus
);

   // Stage 0 is the address just issued; the word lands in the FIFO when it leaves the last stage.
   localparam int unsigned PIPE_N = RD_LAT + 1;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + PIPE_N + 1);

   if (RD_LAT < 1) begin : g_bad_lat
      $error("reg_block_reader: RD_LAT must be at least 1");
   end
   if (FIFO_DEPTH < RD_LAT + 1) begin : g_bad_depth
      $error("reg_block_reader: FIFO_DEPTH must be >= RD_LAT+1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         rem_q, rem_d;
   logic               done_q, done_d;
   logic [PIPE_N-1:0]  pipe_v_q, pipe_l_q;
   logic [CNT_W-1:0]   occ_q;
   logic [PTR_W-1:0]   wr_q, rd_q;
   logic [31:0]        mem_data_q [FIFO_DEPTH];
   logic               mem_last_q [FIFO_DEPTH];

   logic               issue, issue_last;
   logic               push, pop, head_last, credit_ok, flush;
   logic [CNT_W-1:0]   inflight;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < PIPE_N; i++) begin
         inflight = inflight + CNT_W'(pipe_v_q[i]);
      end
      push      = pipe_v_q[PIPE_N-1];
      pop       = (occ_q != '0) && bus.out_ready;
      head_last = mem_last_q[rd_q];
      credit_ok = (occ_q + inflight) < CNT_W'(FIFO_DEPTH);
      flush     = bus.abort;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         done_q   <= 1'b0;
         pipe_v_q <= '0;
         pipe_l_q <= '0;
         occ_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         if (flush) begin
            pipe_v_q <= '0;
            pipe_l_q <= '0;
            occ_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
         end else begin
            pipe_v_q <= {pipe_v_q[PIPE_N-2:0], issue};
            pipe_l_q <= {pipe_l_q[PIPE_N-2:0], issue_last};
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (push) begin
         mem_data_q[wr_q] <= bus.reg_rdata;
         mem_last_q[wr_q] <= pipe_l_q[PIPE_N-1];
      end
   end

   // The first address goes out on the start edge itself, so it is on reg_addr one cycle later.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.count == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  issue      = 1'b1;
                  addr_d     = bus.start_addr;
                  rem_d      = bus.count - 8'd1;
                  issue_last = (bus.count == 8'd1);
                  state_d    = (bus.count == 8'd1) ? DRAIN : ISSUE;
               end
            end
         end
         ISSUE: begin
            if (credit_ok) begin
               issue      = 1'b1;
               addr_d     = addr_q + 8'd1;
               rem_d      = rem_q - 8'd1;
               issue_last = (rem_q == 8'd1);
               if (rem_q == 8'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last && (inflight == '0)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.abort) begin
         state_d    = IDLE;
         addr_d     = addr_q;
         rem_d      = rem_q;
         done_d     = 1'b0;
         issue      = 1'b0;
         issue_last = 1'b0;
      end
   end

   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
      bus.reg_addr  = addr_q;
      bus.out_valid = (occ_q != '0);
      bus.out_last  = (occ_q != '0) && head_last;
      bus.out_data  = (occ_q != '0) ? mem_data_q[rd_q] : '0;
   end

endmodule

// File: tb/tb_reg_block_reader.sv
// Scoreboard bench for reg_block_reader: expected words are queued at start and
// a negedge monitor checks every presented word against the queue head.
module tb_reg_block_reader;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_block_reader_if bus ();

   reg_block_reader #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
      .sysclk (clk),
      .reset  (reset),
      .bus    (bus)
   );

   typedef struct { logic [31:0] d; logic l; } exp_t;
   exp_t       exp_q[$];
   logic [7:0] addr_log[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int done_cnt = 0, done_cyc = 0, busy_cnt = 0, valid_cnt = 0, acc_cnt = 0;
   int first_valid_cyc = -1, start_edge = 0;
   bit log_en = 0, rnd_ready = 0;
   logic [7:0] prev_addr = 8'h00;

   function automatic logic [31:0] regval(input logic [7:0] a);
      if (a == 8'h04) return 32'h514C4131;
      return {a, ~a, a ^ 8'h5A, a + 8'h33};
   endfunction

   // Register file with one clock of read latency.
   initial bus.reg_rdata = '0;
   always @(posedge clk) bus.reg_rdata <= regval(bus.reg_addr);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
         valid_cnt++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", bus.out_data, cyc);
         end else begin
            check("out_data", bus.out_data, exp_q[0].d);
            check("out_last", bus.out_last, exp_q[0].l);
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               acc_cnt++;
            end
         end
      end
      if (log_en && bus.reg_addr != prev_addr) addr_log.push_back(bus.reg_addr);
      prev_addr = bus.reg_addr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_cmd(input logic [7:0] a, input logic [7:0] n);
      logic [7:0] ad;
      for (int i = 0; i < int'(n); i++) begin
         ad = a + 8'(i);
         exp_q.push_back('{regval(ad), (i == int'(n) - 1)});
      end
      bus.start      = 1'b1;
      bus.start_addr = a;
      bus.count      = n;
      first_valid_cyc = -1;
      start_edge      = cyc + 1;
      tick();
      bus.start = 1'b0;
      check("start_busy", bus.busy, (n != 8'd0));
      if (n != 8'd0) check("start_reg_addr", bus.reg_addr, a);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      int d = done_cnt;
      while (done_cnt == d && k < budget) begin
         tick();
         k++;
      end
      if (done_cnt == d) begin
         total++;
         bad++;
         $display("FAIL wait_done: got no done pulse expected one within %0d cycles", budget);
      end
   endtask

   task automatic wait_acc(input int n, input int a0);
      int k = 0;
      while (acc_cnt - a0 < n && k < 200) begin
         tick();
         k++;
      end
      if (acc_cnt - a0 < n) begin
         total++;
         bad++;
         $display("FAIL wait_acc: got %0d words expected %0d", acc_cnt - a0, n);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before 300us");
      $fatal(1);
   end

   initial begin
      int a0, d0, b0, v0;
      logic [7:0] ra, rn, e;
      reset = 1'b0;
      bus.start = 1'b0; bus.start_addr = '0; bus.count = '0;
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_reg_addr", bus.reg_addr, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_data", bus.out_data, 0);
      reset = 1'b1;
      tick(); tick();

      // 16 words from 0x00 with the consumer always ready
      bus.out_ready = 1'b1;
      d0 = done_cnt; a0 = acc_cnt;
      start_cmd(8'h00, 8'd16);
      wait_done(100);
      check("t1_done_cycle", done_cyc - start_edge, 18);
      check("t1_first_valid", first_valid_cyc - start_edge, 2);
      repeat (3) tick();
      check("t1_done_once", done_cnt - d0, 1);
      check("t1_words", acc_cnt - a0, 16);
      check("t1_busy_after", bus.busy, 0);

      // address wrap 0xFE..0x01
      log_en = 1; addr_log.delete();
      start_cmd(8'hFE, 8'd4);
      wait_done(100);
      tick();
      log_en = 0;
      check("t2_addr_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
         e = 8'hFE + 8'(i);
         check("t2_addr_seq", addr_log[i], e);
      end

      // backpressure: only FIFO_DEPTH addresses before the stall
      bus.out_ready = 1'b0;
      log_en = 1; addr_log.delete();
      a0 = acc_cnt;
      start_cmd(8'h40, 8'd8);
      repeat (10) tick();
      check("t3_issued_in_stall", addr_log.size(), 4);
      bus.out_ready = 1'b1;
      wait_done(100);
      tick();
      log_en = 0;
      check("t3_words", acc_cnt - a0, 8);
      check("t3_addr_total", addr_log.size(), 8);
      check("t3_queue_empty", exp_q.size(), 0);

      // zero-length command
      d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
      start_cmd(8'h55, 8'd0);
      repeat (4) tick();
      check("t4_done_once", done_cnt - d0, 1);
      check("t4_done_cycle", done_cyc - start_edge, 0);
      check("t4_no_busy", busy_cnt - b0, 0);
      check("t4_no_valid", valid_cnt - v0, 0);

      // abort after the third accepted word
      a0 = acc_cnt;
      start_cmd(8'h10, 8'd10);
      wait_acc(3, a0);
      d0 = done_cnt;
      bus.abort = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      check("t5_busy_after_abort", bus.busy, 0);
      check("t5_valid_after_abort", bus.out_valid, 0);
      bus.abort = 1'b0;
      exp_q.delete();
      v0 = valid_cnt;
      repeat (8) tick();
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_no_valid", valid_cnt - v0, 0);
      bus.out_ready = 1'b1;
      a0 = acc_cnt;
      start_cmd(8'h20, 8'd2);
      wait_done(100);
      tick();
      check("t5_fresh_words", acc_cnt - a0, 2);
      check("t5_queue_empty", exp_q.size(), 0);

      // asynchronous reset mid-transfer
      a0 = acc_cnt;
      start_cmd(8'h30, 8'd10);
      wait_acc(5, a0);
      #2;
      reset = 1'b0;
      #1;
      check("t6_busy", bus.busy, 0);
      check("t6_done", bus.done, 0);
      check("t6_reg_addr", bus.reg_addr, 0);
      check("t6_out_valid", bus.out_valid, 0);
      check("t6_out_last", bus.out_last, 0);
      check("t6_out_data", bus.out_data, 0);
      exp_q.delete();
      tick(); tick();
      reset = 1'b1;
      d0 = done_cnt; v0 = valid_cnt;
      repeat (10) tick();
      check("t6_no_valid", valid_cnt - v0, 0);
      check("t6_no_done", done_cnt - d0, 0);

      // random ranges with random backpressure
      rnd_ready = 1;
      for (int t = 0; t < 12; t++) begin
         ra = 8'($urandom);
         rn = 8'($urandom_range(1, 20));
         a0 = acc_cnt;
         start_cmd(ra, rn);
         wait_done(500);
         tick();
         check("rand_words", acc_cnt - a0, {24'd0, rn});
         check("rand_queue_empty", exp_q.size(), 0);
      end
      rnd_ready = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
